glyph_renderer: RTL and testbench

Reader side of the 64x8 character ROM: consumes VGA beam coordinates, computes which glyph, row and column of an on-screen text box is under the beam, drives the ROM's `char_enable`/`address` inputs, and serialises the returned 8-bit row into pixel colour. It sits between the VGA sync generator and the RGB output pins. It delays the sync signals so that colour and sync leave the block aligned.

---
 rtl/glyph_renderer_if.sv | 24 ++
 rtl/glyph_renderer.sv | 141 ++++++++++++++
 tb/tb_glyph_renderer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/glyph_renderer_if.sv
// ---------------------------------------------------------------------------
// glyph_renderer_if
// Bundle between the glyph renderer and the 64x8 character ROM.
//   rom_char_enable : renderer -> ROM, row read enable
//   rom_address     : renderer -> ROM, {code[1:0], row[3:0]}
//   rom_data        : ROM -> renderer, combinational row data, bit 7 = leftmost
// ---------------------------------------------------------------------------
interface glyph_renderer_if;
    logic       rom_char_enable;
    logic [5:0] rom_address;
    logic [7:0] rom_data;

    modport master (
        output rom_char_enable,
        output rom_address,
        input  rom_data
    );

    modport slave (
        input  rom_char_enable,
        input  rom_address,
        output rom_data
    );
endinterface

// File: rtl/glyph_renderer.sv
// ---------------------------------------------------------------------------
// glyph_renderer
// Maps VGA beam coordinates onto a fixed on-screen text box, reads the
// matching glyph row from the character ROM and serialises it into colour.
// Two-stage pipeline; syncs are delayed by the same two cycles.
// Ports:
//   clk, reset_n          : pixel clock, synchronous active-low reset
//   video_on              : visible-area flag
//   hsync_in, vsync_in    : active-low syncs from the sync generator
//   pixel_x, pixel_y      : beam coordinates
//   text                  : 2-bit glyph codes, char 0 in bits [1:0]
//   fg_color, bg_color    : glyph-set / glyph-clear colours
//   rom                   : ROM bus (enable, address out; data in)
//   hsync_out, vsync_out  : syncs delayed by 2 cycles
//   rgb_out               : pixel colour, aligned with the delayed syncs
// ---------------------------------------------------------------------------
module glyph_renderer #(
    parameter int unsigned X0         = 288,
    parameter int unsigned Y0         = 224,
    parameter int unsigned NCHARS     = 4,
    parameter int unsigned SCALE_LOG2 = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  video_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic [2*NCHARS-1:0]   text,
    input  logic [2:0]            fg_color,
    input  logic [2:0]            bg_color,
    glyph_renderer_if.master      rom,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic [2:0]            rgb_out
);

    localparam int unsigned BOX_W = (8 * NCHARS) << SCALE_LOG2;
    localparam int unsigned BOX_H = 16 << SCALE_LOG2;

    // 11-bit bounds so that a box ending exactly at 1024 still compares correctly
    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + BOX_W);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + BOX_H);

    if ((X0 + BOX_W > 1024) || (Y0 + BOX_H > 1024) ||
        (NCHARS < 1) || (NCHARS > 8) || (SCALE_LOG2 > 2)) begin : g_bad_params
        $error("glyph_renderer: text box parameters out of range");
    end

    // Frame latch
    logic [2*NCHARS-1:0] text_q;
    logic                vsync_prev_q;

    // Stage 1 registers (rom.* outputs are stage-1 registers too)
    logic [2:0] col_q;
    logic       video_on_q;
    logic       hsync_q;
    logic       vsync_q;

    // Stage 1 next-state
    logic        in_box_d;
    logic [9:0]  dx_d;
    logic [9:0]  dy_d;
    logic [9:0]  cx_d;
    logic [9:0]  cy_d;
    logic [2:0]  char_idx_d;
    logic [15:0] text_pad_d;
    logic [1:0]  code_d;
    logic        enable_d;
    logic [5:0]  address_d;

    // Stage 2 next-state
    logic       pix_bit_d;
    logic [2:0] rgb_d;

    logic unused_bits;

    always_comb begin
        // Raw-coordinate compares, so wrapped dx/dy can never land inside the box
        in_box_d   = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                     ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
        dx_d       = pixel_x - X_LO[9:0];
        dy_d       = pixel_y - Y_LO[9:0];
        cx_d       = dx_d >> SCALE_LOG2;
        cy_d       = dy_d >> SCALE_LOG2;
        char_idx_d = cx_d[5:3];
        // Zero-padded to 8 codes so every char_idx indexes a defined slot
        text_pad_d = 16'(text_q);
        code_d     = text_pad_d[{char_idx_d, 1'b0} +: 2];
        enable_d   = in_box_d & video_on;
        address_d  = in_box_d ? {code_d, cy_d[3:0]} : '0;

        pix_bit_d  = rom.rom_data[3'd7 - col_q];
        if (!video_on_q) begin
            rgb_d = '0;
        end else if (rom.rom_char_enable && pix_bit_d) begin
            rgb_d = fg_color;
        end else begin
            rgb_d = bg_color;
        end
    end

    assign unused_bits = ^{cx_d[9:6], cy_d[9:4]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            text_q              <= '0;
            vsync_prev_q        <= 1'b1;
            rom.rom_char_enable <= 1'b0;
            rom.rom_address     <= '0;
            col_q               <= '0;
            video_on_q          <= 1'b0;
            // Sync pipeline parks at the inactive level so no stray pulse leaves
            hsync_q             <= 1'b1;
            vsync_q             <= 1'b1;
            rgb_out             <= '0;
            hsync_out           <= 1'b1;
            vsync_out           <= 1'b1;
        end else begin
            vsync_prev_q <= vsync_in;
            if (vsync_prev_q && !vsync_in) begin
                text_q <= text;
            end

            rom.rom_char_enable <= enable_d;
            rom.rom_address     <= address_d;
            col_q               <= cx_d[2:0];
            video_on_q          <= video_on;
            hsync_q             <= hsync_in;
            vsync_q             <= vsync_in;

            rgb_out             <= rgb_d;
            hsync_out           <= hsync_q;
            vsync_out           <= vsync_q;
        end
    end

endmodule

// File: tb/tb_glyph_renderer.sv
// ---------------------------------------------------------------------------
// tb_glyph_renderer
// Two renderers (scale 1x and 2x) share all stimulus; the bench models the
// character ROM. Each driven cycle pushes hand-computed expectations into a
// queue; the monitor pops one entry per clock and checks the stage-1 ROM
// outputs immediately and the stage-2 colour/sync one clock later.
// ---------------------------------------------------------------------------
module tb_glyph_renderer;

    localparam logic [2:0] FG = 3'b110;
    localparam logic [2:0] BG = 3'b001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] text;
    logic       hsA, vsA, hsB, vsB;
    logic [2:0] rgbA, rgbB;

    glyph_renderer_if ifA ();
    glyph_renderer_if ifB ();

    always #5 clk = ~clk;

    // Bench-owned ROM contents; only a handful of rows are distinct.
    function automatic logic [7:0] rom_f(input logic [5:0] a);
        case (a)
            6'h00:   rom_f = 8'hFF;        // F row 0
            6'h0F:   rom_f = 8'hC0;        // F row 15
            6'h1F:   rom_f = 8'b00011011;  // Q row 15
            6'h20:   rom_f = 8'h00;        // H row 0
            6'h30:   rom_f = 8'h40;        // X row 0
            default: rom_f = 8'h81;
        endcase
    endfunction

    assign ifA.rom_data = rom_f(ifA.rom_address);
    assign ifB.rom_data = rom_f(ifB.rom_address);

    glyph_renderer #(.X0(288), .Y0(224), .NCHARS(4), .SCALE_LOG2(0)) dutA (
        .clk(clk), .reset_n(reset_n), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .text(text),
        .fg_color(FG), .bg_color(BG), .rom(ifA.master),
        .hsync_out(hsA), .vsync_out(vsA), .rgb_out(rgbA)
    );

    glyph_renderer #(.X0(288), .Y0(224), .NCHARS(4), .SCALE_LOG2(1)) dutB (
        .clk(clk), .reset_n(reset_n), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .text(text),
        .fg_color(FG), .bg_color(BG), .rom(ifB.master),
        .hsync_out(hsB), .vsync_out(vsB), .rgb_out(rgbB)
    );

    typedef struct {
        int         id;
        bit         is_reset;
        bit         chk;
        logic       enA;
        logic [5:0] addrA;
        logic [2:0] rgbA;
        logic       enB;
        logic [5:0] addrB;
        logic [2:0] rgbB;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vid   = 0;

    task automatic check(input string name, input int id,
                         input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s vec%0d: got %0h want %0h", name, id, act, req);
        end
    endtask

    // Monitor: one pop per clock, sampled #1 after the rising edge.
    exp_t prev;
    bit   prev_valid = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            prev_valid = 1'b0;
        end else begin
            e = exp_q.pop_front();
            if (e.is_reset) begin
                check("rst_enA",  e.id, 8'(ifA.rom_char_enable), 8'd0);
                check("rst_addrA", e.id, 8'(ifA.rom_address), 8'd0);
                check("rst_rgbA", e.id, 8'(rgbA), 8'd0);
                check("rst_hsA",  e.id, 8'(hsA), 8'd1);
                check("rst_vsA",  e.id, 8'(vsA), 8'd1);
                check("rst_enB",  e.id, 8'(ifB.rom_char_enable), 8'd0);
                check("rst_rgbB", e.id, 8'(rgbB), 8'd0);
            end else if (e.chk) begin
                check("enA",   e.id, 8'(ifA.rom_char_enable), 8'(e.enA));
                check("addrA", e.id, 8'(ifA.rom_address), 8'(e.addrA));
                check("enB",   e.id, 8'(ifB.rom_char_enable), 8'(e.enB));
                check("addrB", e.id, 8'(ifB.rom_address), 8'(e.addrB));
            end
            if (prev_valid && prev.chk && !prev.is_reset) begin
                check("rgbA", prev.id, 8'(rgbA), 8'(prev.rgbA));
                check("rgbB", prev.id, 8'(rgbB), 8'(prev.rgbB));
                check("hsA",  prev.id, 8'(hsA), 8'(prev.hs));
                check("vsA",  prev.id, 8'(vsA), 8'(prev.vs));
                check("vsB",  prev.id, 8'(vsB), 8'(prev.vs));
            end
            prev       = e;
            prev_valid = 1'b1;
        end
    end

    task automatic vec(input int x, input int y, input logic vo,
                       input logic hs, input logic vs, input logic [7:0] txt,
                       input logic eA, input logic [5:0] aA, input logic [2:0] cA,
                       input logic eB, input logic [5:0] aB, input logic [2:0] cB);
        exp_t e;
        @(negedge clk);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vo;
        hsync_in = hs;
        vsync_in = vs;
        text     = txt;
        e.id = vid; e.is_reset = 1'b0; e.chk = 1'b1;
        e.enA = eA; e.addrA = aA; e.rgbA = cA;
        e.enB = eB; e.addrB = aB; e.rgbB = cB;
        e.hs = hs; e.vs = vs;
        exp_q.push_back(e);
        vid++;
    endtask

    initial begin
        exp_t e;
        reset_n  = 1'b0;
        // Reset held for 3 clocks with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pixel_x  = 10'($urandom);
            pixel_y  = 10'($urandom);
            video_on = 1'($urandom);
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            text     = 8'($urandom);
            e = '{id: vid, is_reset: 1'b1, chk: 1'b0, enA: 1'b0, addrA: '0,
                  rgbA: '0, enB: 1'b0, addrB: '0, rgbB: '0, hs: 1'b1, vs: 1'b1};
            exp_q.push_back(e);
            vid++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back('{id: vid, is_reset: 1'b0, chk: 1'b0, enA: 1'b0, addrA: '0,
                          rgbA: '0, enB: 1'b0, addrB: '0, rgbB: '0, hs: 1'b1, vs: 1'b1});
        vid++;
        hsync_in = 1'b1; vsync_in = 1'b1; video_on = 1'b0;

        // Latched text is all F; the text input already carries Q in char 1
        //   x    y   vo hs vs text   enA addrA  rgbA  enB addrB  rgbB
        vec(288, 224, 1, 1, 1, 8'h04, 1, 6'h00, FG,   1, 6'h00, FG);   // top-left
        vec(287, 224, 1, 1, 1, 8'h04, 0, 6'h00, BG,   0, 6'h00, BG);   // left of box
        vec(320, 224, 1, 1, 1, 8'h04, 0, 6'h00, BG,   1, 6'h00, FG);   // right of 1x box
        vec(300, 230, 0, 1, 1, 8'h04, 0, 6'h06, 3'd0, 0, 6'h03, 3'd0); // blanked
        vec(  0,   0, 0, 0, 1, 8'h04, 0, 6'h00, 3'd0, 0, 6'h00, 3'd0); // hsync low
        vec(303, 239, 1, 1, 1, 8'h04, 1, 6'h0F, BG,   1, 6'h07, FG);   // still F
        // vsync falls: capture 8'h04
        vec(  0,   0, 0, 1, 0, 8'h04, 0, 6'h00, 3'd0, 0, 6'h00, 3'd0);
        // text changes while vsync stays low: ignored
        vec(303, 239, 1, 1, 0, 8'hFF, 1, 6'h1F, FG,   1, 6'h07, FG);   // char1 = Q
        vec(304, 239, 1, 1, 1, 8'hFF, 1, 6'h0F, FG,   1, 6'h17, FG);   // char2 = F
        vec(303, 240, 1, 1, 1, 8'hFF, 0, 6'h00, BG,   1, 6'h08, FG);   // below 1x box
        vec(351, 255, 1, 1, 1, 8'hFF, 0, 6'h00, BG,   1, 6'h0F, BG);   // 2x last pixel
        vec(352, 255, 1, 1, 1, 8'hFF, 0, 6'h00, BG,   0, 6'h00, BG);   // 2x right edge
        vec(351, 256, 1, 1, 1, 8'hFF, 0, 6'h00, BG,   0, 6'h00, BG);   // 2x bottom edge
        vec(289, 225, 1, 1, 1, 8'hFF, 1, 6'h01, BG,   1, 6'h00, FG);
        vec(289, 224, 1, 1, 1, 8'hFF, 1, 6'h00, FG,   1, 6'h00, FG);
        vec(290, 226, 1, 1, 1, 8'hFF, 1, 6'h02, BG,   1, 6'h01, BG);   // 2x col 1
        vec(288, 226, 1, 1, 1, 8'hFF, 1, 6'h02, FG,   1, 6'h01, FG);   // 2x col 0
        // Next frame: capture F,Q,H,X (8'hE4) on the coincident text change
        vec(  0,   0, 0, 1, 0, 8'hE4, 0, 6'h00, 3'd0, 0, 6'h00, 3'd0);
        vec(296, 224, 1, 1, 0, 8'h00, 1, 6'h10, FG,   1, 6'h00, FG);   // char1 Q
        vec(304, 224, 1, 1, 1, 8'h00, 1, 6'h20, BG,   1, 6'h10, FG);   // char2 H
        vec(312, 224, 1, 1, 1, 8'h00, 1, 6'h30, BG,   1, 6'h10, BG);   // char3 X col0
        vec(313, 224, 1, 1, 1, 8'h00, 1, 6'h30, FG,   1, 6'h10, BG);   // char3 X col1

        // Flush: one unchecked entry lets the last stage-2 comparison happen
        @(negedge clk);
        video_on = 1'b0;
        exp_q.push_back('{id: vid, is_reset: 1'b0, chk: 1'b0, enA: 1'b0, addrA: '0,
                          rgbA: '0, enB: 1'b0, addrB: '0, rgbB: '0, hs: 1'b1, vs: 1'b1});

        begin
            int budget;
            budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL drain: got %0d entries left want 0", exp_q.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
